// File: rtl/pdm_playback_tx_pkg.sv
// Shared types and constants for the PDM playback transmitter.
//   sample_t         : signed two's-complement audio sample
//   MIDSCALE         : offset-binary silence code loaded when no sample is available
//   FIFO_DEPTH       : default sample buffer depth (power of 2)
//   PDM_DIV          : default clk cycles per PDM bit
//   BITS_PER_SAMPLE  : default PDM bits emitted per audio sample
//   state_t          : transmitter control states
//   to_offset()      : signed sample -> offset-binary modulator input
package pdm_playback_tx_pkg;

  localparam int SAMPLE_W        = 8;
  localparam int FIFO_DEPTH      = 16;
  localparam int PDM_DIV         = 32;
  localparam int BITS_PER_SAMPLE = 256;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Offset-binary midpoint: 50 % ones density, i.e. silence.
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  // Flipping the sign bit maps -128..+127 onto 0x00..0xFF.
  function automatic logic [SAMPLE_W-1:0] to_offset(input sample_t s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/pdm_playback_tx_if.sv
// Valid/ready sample stream into the playback transmitter.
//   audio_valid_in  : source presents a sample
//   audio_in        : signed sample
//   audio_ready_out : sink can accept (a transfer happens on valid && ready)
// master = sample source, slave = transmitter.
interface pdm_playback_tx_if;
  import pdm_playback_tx_pkg::*;

  logic    audio_valid_in;
  sample_t audio_in;
  logic    audio_ready_out;

  modport master (
    output audio_valid_in,
    output audio_in,
    input  audio_ready_out
  );

  modport slave (
    input  audio_valid_in,
    input  audio_in,
    output audio_ready_out
  );

endinterface

// File: rtl/pdm_playback_tx_sync_fifo.sv
// Single-clock FIFO with registered read data (no first-word fall-through):
// pop_data is valid on the cycle after a pop is accepted.
//   clk, rst    : clock and synchronous active-high reset (empties the FIFO)
//   push        : write request, ignored while full
//   push_data   : write data
//   pop         : read request, ignored while empty
//   pop_data    : registered read data
//   full, empty : occupancy flags (combinational from count)
//   count       : current occupancy, 0..DEPTH
module pdm_playback_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] pop_data_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage and read port carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
    if (do_pop) begin
      pop_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = pop_data_reg;
  assign count    = count_reg;

endmodule

// File: rtl/pdm_playback_tx.sv
// PDM playback transmitter: buffers signed audio samples and re-modulates
// each one into a first-order sigma-delta bit stream.
//   clk_in         : clock, all logic on posedge
//   rst_in         : synchronous active-high reset
//   enable_in      : 1 = play, 0 = stop modulating (FIFO contents kept)
//   audio_bus      : valid/ready sample input (slave side)
//   pdm_out        : registered sigma-delta bit
//   pdm_tick_out   : one-cycle pulse on each cycle pdm_out is updated
//   fifo_count_out : FIFO occupancy
//   underflow_out  : sticky, set when a sample boundary finds the FIFO empty
module pdm_playback_tx
  import pdm_playback_tx_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int DIV   = PDM_DIV,
  parameter int BITS  = BITS_PER_SAMPLE
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   enable_in,
  pdm_playback_tx_if.slave       audio_bus,
  output logic                   pdm_out,
  output logic                   pdm_tick_out,
  output logic [$clog2(DEPTH):0] fifo_count_out,
  output logic                   underflow_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(BITS);

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  sample_t       fifo_rd;
  logic [CW-1:0] fifo_count;

  state_t                state_reg;
  logic [DW-1:0]         div_reg;
  logic [BW-1:0]         bitcnt_reg;
  logic [SAMPLE_W-1:0]   acc_reg;
  logic [SAMPLE_W-1:0]   held_reg;
  logic                  load_pending_reg;
  logic                  pdm_reg;
  logic                  tick_reg;
  logic                  underflow_reg;

  logic                  tick;
  logic                  boundary;
  logic                  prime_go;
  logic [SAMPLE_W:0]     sum;

  pdm_playback_tx_sync_fifo #(
    .WIDTH ($bits(sample_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (audio_bus.audio_valid_in),
    .push_data (audio_bus.audio_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign audio_bus.audio_ready_out = !fifo_full;

  assign tick     = (state_reg == RUN) && (div_reg == DW'(DIV - 1));
  assign boundary = tick && (bitcnt_reg == BW'(BITS - 1));
  assign prime_go = (state_reg == PRIME) && enable_in && (fifo_count >= CW'(DEPTH / 2));
  // No boundary pop on the cycle RUN is being left, so the sample stays buffered.
  assign fifo_pop = prime_go || (boundary && enable_in && !fifo_empty);

  // Carry out of the 9-bit add is the PDM bit; the low byte is the new error.
  assign sum = {1'b0, acc_reg} + {1'b0, held_reg};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg        <= IDLE;
      div_reg          <= '0;
      bitcnt_reg       <= '0;
      acc_reg          <= '0;
      held_reg         <= MIDSCALE;
      load_pending_reg <= 1'b0;
      pdm_reg          <= 1'b0;
      tick_reg         <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      tick_reg         <= 1'b0;
      // FIFO read data lands one cycle after the pop; latch it then.
      load_pending_reg <= fifo_pop;
      if (load_pending_reg) begin
        held_reg <= to_offset(fifo_rd);
      end

      case (state_reg)
        IDLE: begin
          div_reg    <= '0;
          bitcnt_reg <= '0;
          pdm_reg    <= 1'b0;
          if (enable_in) begin
            state_reg <= PRIME;
          end
        end

        PRIME: begin
          if (!enable_in) begin
            state_reg <= IDLE;
          end else if (prime_go) begin
            state_reg <= RUN;
          end
        end

        RUN: begin
          if (!enable_in) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            pdm_reg    <= 1'b0;
            div_reg    <= '0;
            bitcnt_reg <= '0;
          end else begin
            div_reg <= tick ? '0 : div_reg + DW'(1);
            if (tick) begin
              acc_reg    <= sum[SAMPLE_W-1:0];
              pdm_reg    <= sum[SAMPLE_W];
              tick_reg   <= 1'b1;
              bitcnt_reg <= boundary ? '0 : bitcnt_reg + BW'(1);
              // Starved: play silence and keep modulating.
              if (boundary && fifo_empty) begin
                held_reg      <= MIDSCALE;
                underflow_reg <= 1'b1;
              end
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pdm_out        = pdm_reg;
  assign pdm_tick_out   = tick_reg;
  assign fifo_count_out = fifo_count;
  assign underflow_out  = underflow_reg;

endmodule

// File: tb/tb_pdm_playback_tx.sv
// Scoreboard bench for pdm_playback_tx (shortened DIV/BITS for run time).
// Stimulus queues the expected PDM bit for each upcoming tick; a separate
// monitor pops one entry per pdm_tick_out and compares. Status outputs are
// checked directly by the stimulus at chosen points.
module tb_pdm_playback_tx;

  localparam int DEPTH = 16;
  localparam int DIV   = 8;
  localparam int BITS  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       pdm;
  logic       pdm_tick;
  logic [4:0] fifo_count;
  logic       underflow;

  pdm_playback_tx_if bus ();

  pdm_playback_tx #(.DEPTH(DEPTH), .DIV(DIV), .BITS(BITS)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .enable_in      (enable),
    .audio_bus      (bus),
    .pdm_out        (pdm),
    .pdm_tick_out   (pdm_tick),
    .fifo_count_out (fifo_count),
    .underflow_out  (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int tick_seen = 0;
  int ones_seen = 0;
  bit exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Monitor: counts ticks/ones and scores each tick against the queue.
  initial begin
    bit exp_bit;
    forever begin
      @(negedge clk);
      if (rst) begin
        tick_seen = 0;
        ones_seen = 0;
      end else if (pdm_tick) begin
        tick_seen++;
        if (pdm) ones_seen++;
        if (exp_q.size() > 0) begin
          exp_bit = exp_q.pop_front();
          n_cmp++;
          if (pdm !== exp_bit) begin
            n_err++;
            $display("FAIL pdm_bit tick %0d: got %0b expected %0b", tick_seen, pdm, exp_bit);
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] s);
    bus.audio_valid_in = 1'b1;
    bus.audio_in       = s;
    $display("push 0x%02h ready=%0b count=%0d", s, bus.audio_ready_out, fifo_count);
    @(posedge clk); #1;
    bus.audio_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    bus.audio_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_ticks(input int target, input string name);
    int guard = 0;
    while (tick_seen < target && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (tick_seen < target) check(name, tick_seen, target);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    bus.audio_valid_in = 1'b0;
    bus.audio_in       = '0;

    // ---- reset values ----
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pdm", pdm, 0);
    check("rst_tick", pdm_tick, 0);
    check("rst_count", fifo_count, 0);
    check("rst_underflow", underflow, 0);
    check("rst_ready", bus.audio_ready_out, 1);
    rst = 1'b0;

    // ---- zero samples: PRIME waits for 8, 50 % density, then underflow ----
    enable = 1'b1;
    for (int i = 0; i < 7; i++) push(8'h00);
    cycles(4);
    check("prime_count7", fifo_count, 7);
    check("prime_no_ticks", tick_seen, 0);
    for (int i = 0; i < 256; i++) exp_q.push_back(bit'(i % 2));
    push(8'h00);
    wait_ticks(127, "timeout_t127");
    check("underflow_before", underflow, 0);
    wait_ticks(128, "timeout_t128");
    check("underflow_set", underflow, 1);
    wait_ticks(256, "timeout_t256");
    check("ones_zero_sample", ones_seen, 128);
    check("queue_drained_a", exp_q.size(), 0);
    check("underflow_sticky", underflow, 1);
    check("count_empty", fifo_count, 0);
    // ---- reset mid-RUN with 10 buffered ----
    for (int i = 0; i < 10; i++) push(8'h11);
    check("count_before_rst", fifo_count, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_pdm", pdm, 0);
    check("midrst_tick", pdm_tick, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_underflow", underflow, 0);
    check("midrst_ready", bus.audio_ready_out, 1);

    // ---- enable drop mid-sample, then re-enable ----
    do_reset();
    for (int i = 0; i < 12; i++) push(8'h00);
    enable = 1'b1;
    wait_ticks(20, "timeout_d20");
    check("count_after_pops", fifo_count, 10);
    check("pdm_before_stop", pdm, 1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("stop_pdm", pdm, 0);
    check("stop_tick", pdm_tick, 0);
    t = tick_seen;
    cycles(40);
    check("ticks_stopped", tick_seen, t);
    check("count_kept", fifo_count, 10);
    enable = 1'b1;
    cycles(3);
    check("reprime_pop", fifo_count, 9);
    wait_ticks(t + 2, "timeout_resume");
    check("ticks_resumed", (tick_seen >= t + 2) ? 1 : 0, 1);

    // ---- full FIFO, dropped 17th push, +127 density ----
    do_reset();
    for (int i = 0; i < 16; i++) push(8'h7F);
    check("full_ready", bus.audio_ready_out, 0);
    check("full_count", fifo_count, 16);
    push(8'h80);
    check("drop_count", fifo_count, 16);
    for (int i = 0; i < 256; i++) exp_q.push_back(bit'(i != 0));
    enable = 1'b1;
    cycles(3);
    check("ready_restored", bus.audio_ready_out, 1);
    check("count_after_prime", fifo_count, 15);
    wait_ticks(256, "timeout_b256");
    check("ones_max_sample", ones_seen, 255);
    check("queue_drained_b", exp_q.size(), 0);

    // ---- -128: output never high ----
    do_reset();
    for (int i = 0; i < 16; i++) push(8'h80);
    for (int i = 0; i < 256; i++) exp_q.push_back(1'b0);
    enable = 1'b1;
    wait_ticks(256, "timeout_c256");
    check("ones_min_sample", ones_seen, 0);
    check("queue_drained_c", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
